btb_update_queue: RTL and testbench

- Writer side of the branch target buffer. Accepts resolved-branch updates (pc, target, taken) from the branch resolution / commit stage.
- Buffers taken branches in a small in-order FIFO.
- Drains each entry into the BTB write port. Before every write it does a check-port read, so writes that would not change the BTB are suppressed.
- Sits between the branch-resolution bus and the BTB's check/write/pc_curr_update/pc_out_br_bus/pc_out_check ports.

---
 rtl/btb_update_queue.sv | 92 +++++++++
 tb/tb_btb_update_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_queue.sv
// Writer side of the BTB: queues taken branch updates and drains them as check-then-write.
// Latency: head checked 1 cycle after accept into an empty queue; a check miss writes 1 cycle later.
// Backpressure: upd_ready = !q_full from registered occupancy; no pass-through when full.
module btb_update_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [31:0]              upd_pc,
    input  logic [31:0]              upd_target,
    input  logic                     upd_taken,
    output logic                     btb_check,
    output logic                     btb_write,
    output logic [31:0]              btb_pc_update,
    output logic [31:0]              btb_target,
    input  logic [31:0]              btb_check_data,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     q_full,
    output logic                     q_empty,
    output logic [CNT_W-1:0]         write_cnt,
    output logic [CNT_W-1:0]         skip_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {CHECK = 1'b0, WRITE = 1'b1} state_t;

    state_t      state;
    logic [31:0] pc_mem  [DEPTH];
    logic [31:0] tgt_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0] head_pc;
    logic [31:0] head_tgt;
    logic        push;
    logic        pop;
    logic        check_act;
    logic        write_act;
    logic        hit;

    assign q_full    = (q_count == FULL_CNT);
    assign q_empty   = (q_count == '0);
    assign upd_ready = !q_full;
    assign push      = upd_valid && upd_ready && upd_taken;
    assign head_pc   = pc_mem[rd_ptr];
    assign head_tgt  = tgt_mem[rd_ptr];

    // Gated by rst so a reset cycle never lets a discarded entry reach the BTB.
    assign check_act = rst && (state == CHECK) && !q_empty;
    assign write_act = rst && (state == WRITE);
    assign hit       = check_act && (btb_check_data == head_tgt);
    assign pop       = hit || write_act;

    assign btb_check     = check_act;
    assign btb_write     = write_act;
    assign btb_pc_update = (check_act || write_act) ? head_pc  : '0;
    assign btb_target    = (check_act || write_act) ? head_tgt : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= upd_pc;
            tgt_mem[wr_ptr] <= upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            q_count   <= '0;
            state     <= CHECK;
            write_cnt <= '0;
            skip_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
            if (check_act && !hit) state <= WRITE;
            else if (write_act)    state <= CHECK;
            if (hit && skip_cnt != CNT_MAX)        skip_cnt  <= skip_cnt + 1'b1;
            if (write_act && write_cnt != CNT_MAX) write_cnt <= write_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_btb_update_queue.sv
// Randomized + directed bench: a negedge monitor scores DUT drain traffic against a queue model and a BTB array.
module tb_btb_update_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_ready;
    logic        btb_check;
    logic        btb_write;
    logic [31:0] btb_pc_update;
    logic [31:0] btb_target;
    logic [31:0] btb_check_data;
    logic [$clog2(DEPTH):0] q_count;
    logic        q_full;
    logic        q_empty;
    logic [CNT_W-1:0] write_cnt;
    logic [CNT_W-1:0] skip_cnt;

    always #5 clk = ~clk;

    btb_update_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .btb_check(btb_check), .btb_write(btb_write),
        .btb_pc_update(btb_pc_update), .btb_target(btb_target),
        .btb_check_data(btb_check_data),
        .q_count(q_count), .q_full(q_full), .q_empty(q_empty),
        .write_cnt(write_cnt), .skip_cnt(skip_cnt)
    );

    // Behavioural BTB: one target per pc[7:2], read combinationally.
    logic [31:0] btb_mem [64];
    logic        clr_btb = 1'b0;
    assign btb_check_data = btb_mem[btb_pc_update[7:2]];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
    } ent_t;

    ent_t exp_q[$];
    bit   pend = 0;
    int   exp_wr = 0;
    int   exp_sk = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   saw_stall = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor / scoreboard
    initial forever begin
        int  sz;
        bit  acc;
        @(negedge clk);
        if (clr_btb) foreach (btb_mem[i]) btb_mem[i] = '0;
        if (!rst) begin
            chk("rst_gate_check", 64'(btb_check), 64'(0));
            chk("rst_gate_write", 64'(btb_write), 64'(0));
            exp_q.delete();
            pend   = 0;
            exp_wr = 0;
            exp_sk = 0;
        end else begin
            sz  = exp_q.size();
            acc = upd_valid && (sz < DEPTH);
            chk("q_count",   64'(q_count),   64'(sz));
            chk("upd_ready", 64'(upd_ready), 64'(sz < DEPTH));
            chk("q_full",    64'(q_full),    64'(sz == DEPTH));
            chk("q_empty",   64'(q_empty),   64'(sz == 0));
            chk("write_cnt", 64'(write_cnt), 64'(exp_wr));
            chk("skip_cnt",  64'(skip_cnt),  64'(exp_sk));
            if (pend) begin
                chk("wr_write",  64'(btb_write),     64'(1));
                chk("wr_check",  64'(btb_check),     64'(0));
                chk("wr_pc",     64'(btb_pc_update), 64'(exp_q[0].pc));
                chk("wr_target", 64'(btb_target),    64'(exp_q[0].tgt));
                btb_mem[exp_q[0].pc[7:2]] = exp_q[0].tgt;
                void'(exp_q.pop_front());
                exp_wr++;
                pend = 0;
            end else if (sz != 0) begin
                chk("ck_check",  64'(btb_check),     64'(1));
                chk("ck_write",  64'(btb_write),     64'(0));
                chk("ck_pc",     64'(btb_pc_update), 64'(exp_q[0].pc));
                chk("ck_target", 64'(btb_target),    64'(exp_q[0].tgt));
                if (btb_mem[exp_q[0].pc[7:2]] == exp_q[0].tgt) begin
                    void'(exp_q.pop_front());
                    exp_sk++;
                end else begin
                    pend = 1;
                end
            end else begin
                chk("idle_check",  64'(btb_check),     64'(0));
                chk("idle_write",  64'(btb_write),     64'(0));
                chk("idle_pc",     64'(btb_pc_update), 64'(0));
                chk("idle_target", 64'(btb_target),    64'(0));
            end
            if (acc && upd_taken) exp_q.push_back('{pc: upd_pc, tgt: upd_target});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        clr_btb = 1'b1;
        repeat (n) cyc();
        rst = 1'b1;
        clr_btb = 1'b0;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        int n = 0;
        upd_valid = 1'b1;
        upd_pc = pc;
        upd_target = tgt;
        upd_taken = tk;
        forever begin
            @(negedge clk);
            if (upd_ready) break;
            saw_stall = 1;
            n++;
            if (n > 100) begin
                chk("send_timeout", 64'(1), 64'(0));
                break;
            end
        end
        cyc();
        upd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (q_empty && !btb_check && !btb_write) break;
            n++;
            if (n > 200) begin
                chk("idle_timeout", 64'(1), 64'(0));
                break;
            end
        end
        cyc();
    endtask

    initial begin
        bit hold;
        int n;
        // Reset held 2 cycles with a valid taken update on the bus.
        rst = 1'b0; clr_btb = 1'b1;
        upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = 32'h40; upd_target = 32'h100;
        repeat (2) cyc();
        rst = 1'b1; clr_btb = 1'b0; upd_valid = 1'b0;
        @(negedge clk);
        chk("reset_q_count", 64'(q_count),   64'(0));
        chk("reset_ready",   64'(upd_ready), 64'(1));
        chk("reset_check",   64'(btb_check), 64'(0));
        chk("reset_write",   64'(btb_write), 64'(0));
        chk("reset_wcnt",    64'(write_cnt), 64'(0));
        chk("reset_scnt",    64'(skip_cnt),  64'(0));
        cyc();

        // Single miss: check at N+1, write at N+2, empty at N+3.
        send(32'h40, 32'h100, 1'b1);
        @(negedge clk);
        chk("miss_check_n1", 64'(btb_check),     64'(1));
        chk("miss_pc_n1",    64'(btb_pc_update), 64'(32'h40));
        @(negedge clk);
        chk("miss_write_n2", 64'(btb_write),     64'(1));
        chk("miss_tgt_n2",   64'(btb_target),    64'(32'h100));
        @(negedge clk);
        chk("miss_empty_n3", 64'(q_empty),       64'(1));
        chk("miss_wcnt",     64'(write_cnt),     64'(1));
        cyc();

        // Check hit: BTB already holds 0x100 for pc 0x40.
        send(32'h40, 32'h100, 1'b1);
        @(negedge clk);
        chk("hit_check", 64'(btb_check), 64'(1));
        @(negedge clk);
        chk("hit_nowrite", 64'(btb_write), 64'(0));
        chk("hit_empty",   64'(q_empty),   64'(1));
        chk("hit_scnt",    64'(skip_cnt),  64'(1));
        cyc();

        // Not-taken filter.
        send(32'h80, 32'h200, 1'b0);
        @(negedge clk);
        chk("nt_count", 64'(q_count),   64'(0));
        chk("nt_check", 64'(btb_check), 64'(0));
        chk("nt_ready", 64'(upd_ready), 64'(1));
        cyc();

        // Full/backpressure: consecutive misses outpace the 1-per-2 drain.
        do_reset(1);
        saw_stall = 0;
        for (int i = 0; i < 8; i++) send(32'h100 + 32'(i * 4), 32'h1000 + 32'(i * 16), 1'b1);
        chk("full_stalled", 64'(saw_stall), 64'(1));
        wait_idle();
        chk("full_wcnt", 64'(write_cnt), 64'(8));

        // Duplicate pc: first written, second hits the fresh BTB entry.
        do_reset(1);
        send(32'h40, 32'h100, 1'b1);
        send(32'h40, 32'h100, 1'b1);
        wait_idle();
        chk("dup_wcnt", 64'(write_cnt), 64'(1));
        chk("dup_scnt", 64'(skip_cnt),  64'(1));

        // Reset in WRITE with 3 entries queued.
        do_reset(1);
        for (int i = 0; i < 6; i++) send(32'h200 + 32'(i * 4), 32'h2000 + 32'(i * 16), 1'b1);
        n = 0;
        forever begin
            @(negedge clk);
            if (btb_check && (btb_check_data != btb_target) && q_count == 3) break;
            n++;
            if (n > 50) begin
                chk("mid_timeout", 64'(1), 64'(0));
                break;
            end
        end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_write", 64'(btb_write), 64'(0));
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_post_write", 64'(btb_write), 64'(0));
            chk("mid_post_empty", 64'(q_empty),   64'(1));
        end
        cyc();

        // Randomized traffic with occasional resets; BTB contents persist across resets.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                upd_valid  = ($urandom_range(0, 9) < 7);
                upd_taken  = ($urandom_range(0, 3) != 0);
                upd_pc     = 32'h40 + 32'($urandom_range(0, 11) << 2);
                upd_target = 32'h1000 + 32'($urandom_range(0, 3) << 4);
            end
            rst = ($urandom_range(0, 299) != 0);
            @(negedge clk);
            hold = upd_valid && !(upd_ready && rst);
            cyc();
        end
        rst = 1'b1;
        upd_valid = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
